// File: rtl/cdp1802_uart.sv
// CDP1802 I/O-bus UART: 8N1 transmitter with holding register, receiver with small FIFO, status on EF.
// Define CDP1802_UART_LOOPBACK_EN to feed the receiver from the internal txd instead of the rxd pin.
module cdp1802_uart #(
    parameter int CLKS_PER_BIT = 217,
    parameter int RX_DEPTH     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] n,
    input  logic [7:0] bus_out,
    output logic [7:0] bus_in,
    output logic [3:0] EF,
    input  logic       rxd,
    output logic       txd
);

    localparam int CLK_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(RX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CLK_W-1:0] BIT_LAST  = CLK_W'(CLKS_PER_BIT - 1);
    localparam logic [CLK_W-1:0] HALF_LAST = CLK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    logic wr_tx, rd_rx, wr_clr;
    assign wr_tx  = (n == 3'd1);
    assign rd_rx  = (n == 3'd2);
    assign wr_clr = (n == 3'd3);

    // ---------------- transmitter ----------------
    uart_state_t      tx_state_reg, tx_state_next;
    logic [CLK_W-1:0] tx_clk_reg, tx_clk_next;
    logic [2:0]       tx_bit_reg, tx_bit_next;
    logic [7:0]       tx_shift_reg, tx_shift_next;
    logic [7:0]       hold_reg;
    logic             hold_full_reg;
    logic             txd_reg;
    logic             tx_load;
    logic             tx_line;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_clk_next   = tx_clk_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_load       = 1'b0;
        case (tx_state_reg)
            IDLE: begin
                if (hold_full_reg) begin
                    tx_load       = 1'b1;
                    tx_shift_next = hold_reg;
                    tx_clk_next   = '0;
                    tx_state_next = START;
                end
            end
            START: begin
                if (tx_clk_reg == BIT_LAST) begin
                    tx_clk_next   = '0;
                    tx_bit_next   = '0;
                    tx_state_next = DATA;
                end else begin
                    tx_clk_next = tx_clk_reg + 1'b1;
                end
            end
            DATA: begin
                if (tx_clk_reg == BIT_LAST) begin
                    tx_clk_next   = '0;
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    if (tx_bit_reg == 3'd7) tx_state_next = STOP;
                    else                    tx_bit_next   = tx_bit_reg + 1'b1;
                end else begin
                    tx_clk_next = tx_clk_reg + 1'b1;
                end
            end
            STOP: begin
                if (tx_clk_reg == BIT_LAST) begin
                    tx_clk_next = '0;
                    // A waiting byte starts immediately so frames run back-to-back.
                    if (hold_full_reg) begin
                        tx_load       = 1'b1;
                        tx_shift_next = hold_reg;
                        tx_state_next = START;
                    end else begin
                        tx_state_next = IDLE;
                    end
                end else begin
                    tx_clk_next = tx_clk_reg + 1'b1;
                end
            end
            default: tx_state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        case (tx_state_reg)
            START:   tx_line = 1'b0;
            DATA:    tx_line = tx_shift_reg[0];
            default: tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_reg  <= IDLE;
            tx_clk_reg    <= '0;
            tx_bit_reg    <= '0;
            tx_shift_reg  <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            txd_reg       <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_clk_reg   <= tx_clk_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            txd_reg      <= tx_line;
            if (wr_tx && !hold_full_reg) begin
                hold_reg      <= bus_out;
                hold_full_reg <= 1'b1;
            end else if (tx_load) begin
                hold_full_reg <= 1'b0;
            end
        end
    end

    assign txd = txd_reg;

    // ---------------- receiver ----------------
    logic rx_src;
`ifdef CDP1802_UART_LOOPBACK_EN
    logic unused_rxd;
    assign unused_rxd = rxd;
    assign rx_src     = txd_reg;
`else
    assign rx_src = rxd;
`endif

    logic             rx_meta_reg, rx_sync_reg, rx_prev_reg;
    uart_state_t      rx_state_reg, rx_state_next;
    logic [CLK_W-1:0] rx_clk_reg, rx_clk_next;
    logic [2:0]       rx_bit_reg, rx_bit_next;
    logic [7:0]       rx_shift_reg, rx_shift_next;
    logic             rx_push, frame_set;

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_clk_next   = rx_clk_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_push       = 1'b0;
        frame_set     = 1'b0;
        case (rx_state_reg)
            IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_clk_next   = '0;
                    rx_state_next = START;
                end
            end
            START: begin
                // HALF_LAST absorbs the one-cycle edge-detect delay so samples land mid-bit.
                if (rx_clk_reg == HALF_LAST) begin
                    rx_clk_next = '0;
                    rx_bit_next = '0;
                    if (rx_sync_reg) rx_state_next = IDLE;
                    else             rx_state_next = DATA;
                end else begin
                    rx_clk_next = rx_clk_reg + 1'b1;
                end
            end
            DATA: begin
                if (rx_clk_reg == BIT_LAST) begin
                    rx_clk_next   = '0;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    if (rx_bit_reg == 3'd7) rx_state_next = STOP;
                    else                    rx_bit_next   = rx_bit_reg + 1'b1;
                end else begin
                    rx_clk_next = rx_clk_reg + 1'b1;
                end
            end
            STOP: begin
                if (rx_clk_reg == BIT_LAST) begin
                    rx_clk_next   = '0;
                    rx_state_next = IDLE;
                    if (rx_sync_reg) rx_push   = 1'b1;
                    else             frame_set = 1'b1;
                end else begin
                    rx_clk_next = rx_clk_reg + 1'b1;
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_state_reg <= IDLE;
            rx_clk_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
        end else begin
            rx_meta_reg  <= rx_src;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            rx_state_reg <= rx_state_next;
            rx_clk_reg   <= rx_clk_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    // ---------------- RX FIFO and sticky flags ----------------
    logic [7:0]          fifo_mem [RX_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    rx_count_reg;
    logic [RX_DEPTH-1:0] entry_we;
    logic                rx_avail, pop, push_ok, overrun_set;
    logic                overrun_reg, frame_reg;

    assign rx_avail = (rx_count_reg != '0);
    assign pop      = rd_rx && rx_avail;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok     = rx_push && ((rx_count_reg != FULL_CNT) || pop);
    assign overrun_set = rx_push && (rx_count_reg == FULL_CNT) && !pop;

    genvar gi;
    for (gi = 0; gi < RX_DEPTH; gi = gi + 1) begin : g_entry_we
        assign entry_we[gi] = push_ok && (wr_ptr_reg == PTR_W'(gi));
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < RX_DEPTH; i++) begin
            if (entry_we[i]) fifo_mem[i] <= rx_shift_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            rx_count_reg <= '0;
            overrun_reg  <= 1'b0;
            frame_reg    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   rx_count_reg <= rx_count_reg + 1'b1;
                2'b01:   rx_count_reg <= rx_count_reg - 1'b1;
                default: rx_count_reg <= rx_count_reg;
            endcase
            overrun_reg <= overrun_set | (overrun_reg & ~(wr_clr & bus_out[0]));
            frame_reg   <= frame_set   | (frame_reg   & ~(wr_clr & bus_out[1]));
        end
    end

    assign EF = {frame_reg, overrun_reg, ~hold_full_reg, rx_avail};

    always_comb begin
        bus_in = '0;
        case (n)
            3'd2: if (rx_avail) bus_in = fifo_mem[rd_ptr_reg];
            3'd4: bus_in = {4'b0000, EF};
            default: bus_in = '0;
        endcase
    end

endmodule
